serial_parity_checker: RTL and testbench

- Receive side of the odd-parity link. The transmitter appends p = XNOR-reduction of the data word, so the total count of ones across data and p is odd.
- The block deserialises one frame, LSB first: a start strobe, then DATA_W data bits, then one parity bit.
- It reports the recovered word together with a parity verdict.
- It sits between the serial line front-end and the word-level consumer.

---
 rtl/serial_parity_pkg.sv | 21 ++
 rtl/parity_acc.sv | 36 +++
 rtl/serial_parity_checker.sv | 150 +++++++++++++++
 tb/tb_serial_parity_checker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_parity_pkg.sv
// Shared types and helpers for the odd-parity serial link.
// Used by serial_parity_checker (optional FRAME_TIMEOUT_EN) and by its bench.
package serial_parity_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      DONE
   } state_e;

   localparam logic PARITY_ODD = 1'b1;

   // Parity bit a transmitter appends to the low 'width' bits of data.
   function automatic logic calc_parity(input logic [31:0] data, input int unsigned width);
      logic [31:0] mask;
      mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
      return ~^(data & mask);
   endfunction

endpackage

// File: rtl/parity_acc.sv
// 1-bit XOR accumulator with synchronous clear and enable.
// Shared with the transmitter, which inverts acc to form its XNOR parity bit.
module parity_acc (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic bit_in,
   output logic acc
);

   logic acc_q;
   logic acc_d;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = 1'b0;
      end else if (en) begin
         acc_d = acc_q ^ bit_in;
      end
   end

   // NOTE: state flops use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Receive-side deserialiser for the odd-parity link: start, DATA_W bits LSB first, parity.
// Define FRAME_TIMEOUT_EN to abort stalled frames after TIMEOUT idle cycles (adds err_timeout).
module serial_parity_checker
   import serial_parity_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              bit_in,
   input  logic              bit_valid,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              parity_ok,
`ifdef FRAME_TIMEOUT_EN
   output logic              err_timeout,
`endif
   output logic              busy
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   if (DATA_W < 2 || DATA_W > 32 || TIMEOUT < 1) begin : g_bad_param
      $error("serial_parity_checker: DATA_W must be 2..32 and TIMEOUT at least 1");
   end

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              parity_ok_q, parity_ok_d;
   logic              data_valid_q, data_valid_d;
   logic              acc_clr, acc_en, acc_q;

`ifdef FRAME_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              err_timeout_q, err_timeout_d;
`endif

   parity_acc u_parity_acc (
      .clk    (clk),
      .rst    (rst),
      .clr    (acc_clr),
      .en     (acc_en),
      .bit_in (bit_in),
      .acc    (acc_q)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      shift_d      = shift_q;
      data_out_d   = data_out_q;
      parity_ok_d  = parity_ok_q;
      data_valid_d = 1'b0;
      acc_clr      = 1'b0;
      acc_en       = 1'b0;

      case (state_q)
         IDLE: begin
            // A bit_valid coincident with start is deliberately dropped.
            if (start) begin
               state_d = DATA;
               cnt_d   = '0;
               acc_clr = 1'b1;
            end
         end
         DATA: begin
            if (bit_valid) begin
               shift_d[cnt_q] = bit_in;
               acc_en         = 1'b1;
               if (cnt_q == LAST_BIT) begin
                  state_d = PARITY;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         PARITY: begin
            if (bit_valid) begin
               acc_en       = 1'b1;
               data_out_d   = shift_q;
               parity_ok_d  = ((acc_q ^ bit_in) == PARITY_ODD);
               data_valid_d = 1'b1;
               state_d      = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef FRAME_TIMEOUT_EN
      idle_d        = '0;
      err_timeout_d = 1'b0;
      if ((state_q == DATA || state_q == PARITY) && !bit_valid) begin
         if (idle_q == IDLE_LAST) begin
            state_d       = IDLE;
            err_timeout_d = 1'b1;
         end else begin
            idle_d = idle_q + IDLE_W'(1);
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         shift_q      <= '0;
         data_out_q   <= '0;
         parity_ok_q  <= 1'b0;
         data_valid_q <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
         idle_q        <= '0;
         err_timeout_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shift_q      <= shift_d;
         data_out_q   <= data_out_d;
         parity_ok_q  <= parity_ok_d;
         data_valid_q <= data_valid_d;
`ifdef FRAME_TIMEOUT_EN
         idle_q        <= idle_d;
         err_timeout_q <= err_timeout_d;
`endif
      end
   end

   assign data_out   = data_out_q;
   assign parity_ok  = parity_ok_q;
   assign data_valid = data_valid_q;
   assign busy       = (state_q != IDLE);
`ifdef FRAME_TIMEOUT_EN
   assign err_timeout = err_timeout_q;
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Self-checking bench for serial_parity_checker: directed frames plus randomized frames.
// Reference verdict is the ones-count of data plus parity bit being odd.
module tb_serial_parity_checker;
   import serial_parity_pkg::*;

   localparam int DW = 8;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          bit_in;
   logic          bit_valid;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          parity_ok;
   logic          busy;
`ifdef FRAME_TIMEOUT_EN
   logic          err_timeout;
`endif

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] last_word;
   logic          last_ok;

   always #5 clk = ~clk;

   serial_parity_checker #(.DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .data_out   (data_out),
      .data_valid (data_valid),
      .parity_ok  (parity_ok),
`ifdef FRAME_TIMEOUT_EN
      .err_timeout(err_timeout),
`endif
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic s, input logic bv, input logic b);
      @(negedge clk);
      start     = s;
      bit_valid = bv;
      bit_in    = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One frame; 'stall' idle cycles precede data bit index 2, 'gap' precede every other bit.
   task automatic send_frame(input logic [DW-1:0] word, input logic pbit, input int gap,
                             input int stall, input bit noisy, input string tag);
      logic [DW:0] bits;
      logic        exp_ok;
      int          g;
      bits   = {pbit, word};
      exp_ok = ($countones(bits) % 2) == 1;

      drive(1'b1, noisy, noisy ? ~word[0] : 1'b0);
      tick();
      check({tag, " busy after start"}, busy, 1);

      for (int i = 0; i <= DW; i++) begin
         g = (i == 2) ? stall : gap;
         for (int j = 0; j < g; j++) begin
            drive(noisy && (1'($urandom_range(1)) == 1'b1), 1'b0, 1'($urandom_range(1)));
            tick();
            check({tag, " no early data_valid"}, data_valid, 0);
`ifdef FRAME_TIMEOUT_EN
            check({tag, " no timeout in gap"}, err_timeout, 0);
`endif
         end
         drive(noisy && (1'($urandom_range(1)) == 1'b1), 1'b1, bits[i]);
         tick();
         if (i < DW) begin
            check({tag, " no data_valid on data bit"}, data_valid, 0);
         end else begin
            check({tag, " data_valid after parity"}, data_valid, 1);
            check({tag, " data_out"}, data_out, word);
            check({tag, " parity_ok"}, parity_ok, exp_ok);
         end
      end

      // bit_valid during DONE must be ignored.
      drive(1'b0, 1'b1, 1'($urandom_range(1)));
      tick();
      check({tag, " data_valid one cycle"}, data_valid, 0);
      check({tag, " busy low after done"}, busy, 0);
      check({tag, " data_out held"}, data_out, word);
      check({tag, " parity_ok held"}, parity_ok, exp_ok);
      drive(1'b0, 1'b0, 1'b0);
      last_word = word;
      last_ok   = exp_ok;
   endtask

   initial begin
      logic [DW-1:0] w;
      logic          p;
      int            err_cnt;
      int            err_at;
      int            dv_cnt;

      rst       = 1'b1;
      start     = 1'b0;
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      #1;
      check("reset data_out", data_out, 0);
      check("reset parity_ok", parity_ok, 0);
      check("reset data_valid", data_valid, 0);
      check("reset busy", busy, 0);
`ifdef FRAME_TIMEOUT_EN
      check("reset err_timeout", err_timeout, 0);
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // bit_valid alone in IDLE does not start a frame.
      repeat (3) begin
         drive(1'b0, 1'b1, 1'b1);
         tick();
         check("idle ignores bit_valid", busy, 0);
      end

      send_frame(8'hA5, 1'b1, 0, 0, 1'b0, "good_a5");
      send_frame(8'h01, 1'b1, 0, 0, 1'b0, "bad_01");
      send_frame(8'hFF, 1'b1, 3, 3, 1'b0, "gapped_ff");

      // Reset after the 4th data bit aborts the frame.
      drive(1'b1, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 1'b1);
         tick();
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midreset data_out", data_out, 0);
      check("midreset parity_ok", parity_ok, 0);
      check("midreset busy", busy, 0);
      check("midreset data_valid", data_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      dv_cnt = 0;
      for (int i = 0; i < DW; i++) begin
         drive(1'b0, 1'b1, 1'b1);
         tick();
         dv_cnt += int'(data_valid);
      end
      check("midreset no data_valid", dv_cnt, 0);
      check("midreset stays idle", busy, 0);
      send_frame(8'h3C, 1'b1, 0, 0, 1'b0, "after_reset_3c");

      // start during DATA and start+bit_valid in IDLE are ignored.
      send_frame(8'h96, 1'b1, 2, 2, 1'b1, "start_noise_96");

`ifdef FRAME_TIMEOUT_EN
      // 16 idle cycles after bit 2 abort the frame.
      drive(1'b1, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 1'b0);
         tick();
      end
      err_cnt = 0;
      err_at  = -1;
      dv_cnt  = 0;
      for (int i = 1; i <= TO + 4; i++) begin
         drive(1'b0, 1'b0, 1'b0);
         tick();
         if (err_timeout === 1'b1) begin
            err_cnt++;
            if (err_at < 0) err_at = i;
         end
         dv_cnt += int'(data_valid);
      end
      check("timeout pulse count", err_cnt, 1);
      check("timeout pulse cycle", err_at, TO);
      check("timeout no data_valid", dv_cnt, 0);
      check("timeout busy low", busy, 0);
      check("timeout data_out held", data_out, last_word);
      check("timeout parity_ok held", parity_ok, last_ok);
      send_frame(8'h5A, 1'b0, 0, TO - 1, 1'b0, "stall15_5a");
`else
      send_frame(8'h5A, 1'b0, 0, 20, 1'b0, "long_stall_5a");
`endif

      for (int k = 0; k < 24; k++) begin
         w = DW'($urandom);
         p = calc_parity(32'(w), DW);
         if ($urandom_range(3) == 0) p = ~p;
         send_frame(w, p, int'($urandom_range(2)), int'($urandom_range(2)),
                    1'($urandom_range(1)), $sformatf("rand%0d", k));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
